// File: rtl/loba_pkg.sv
// Shared widths, S1 operand record and leading-one helper for the LOBA multiplier.
// LOBA_ROUND_EN widens the segment by one bit for midpoint compensation.
package loba_pkg;

   localparam int LOBA_N = 16;
   localparam int LOBA_K = 4;

`ifdef LOBA_ROUND_EN
   localparam int SEGW = LOBA_K + 1;
`else
   localparam int SEGW = LOBA_K;
`endif

   localparam int SHW   = $clog2(LOBA_N) + 1;
   localparam int PRODW = 2 * SEGW;

   typedef struct packed {
      logic [SEGW-1:0] seg;
      logic [SHW-1:0]  sh;
      logic            sign;
   } loba_op_t;

   // Index of the highest set bit; 0 for a zero input.
   function automatic logic [SHW-1:0] lead_one(input logic [LOBA_N-1:0] m);
      lead_one = '0;
      for (int i = 0; i < LOBA_N; i++) begin
         if (m[i]) lead_one = SHW'(i);
      end
   endfunction

endpackage

// File: rtl/loba_seg.sv
// Combinational magnitude, leading-one detect and segment extraction for one operand.
// LOBA_ROUND_EN appends a midpoint bit to truncated segments.
module loba_seg
   import loba_pkg::*;
#(
   parameter int N      = LOBA_N,
   parameter int K      = LOBA_K,
   parameter bit SIGNED = 1'b0
) (
   input  logic [N-1:0] x,
   output loba_op_t     op
);

   logic           neg;
   logic [N-1:0]   mag;
   logic [SHW-1:0] p;
   logic [SHW-1:0] sh;
   logic [N-1:0]   shifted;
   logic [K-1:0]   seg_k;

   always_comb begin
      neg = SIGNED && x[N-1];
      // -2^(N-1) negates to itself, which reads correctly as an unsigned magnitude
      mag = neg ? (~x + 1'b1) : x;
      p   = lead_one(mag);
      if ((mag >> K) == '0) sh = '0;
      else                  sh = p - SHW'(K - 1);
      shifted = mag >> sh;
      seg_k   = shifted[K-1:0];

      op      = '0;
      op.sign = neg;
      op.sh   = sh;
`ifdef LOBA_ROUND_EN
      if (sh != '0) begin
         op.seg = {seg_k, 1'b1};
         op.sh  = sh - 1'b1;
      end else begin
         op.seg = {1'b0, seg_k};
      end
`else
      op.seg = seg_k;
`endif
   end

endmodule

// File: rtl/loba_mult_pipe.sv
// Three-stage LOBA approximate multiplier with valid/ready on both sides.
// Build with LOBA_ROUND_EN for midpoint-compensated segments.
module loba_mult_pipe
   import loba_pkg::*;
#(
   parameter int N      = LOBA_N,
   parameter int K      = LOBA_K,
   parameter bit SIGNED = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out_p
);

   // The S1 record type is sized from the package, so the widths must agree.
   if (N != LOBA_N || K != LOBA_K) begin : g_cfg_check
      $error("loba_mult_pipe: N/K must match loba_pkg LOBA_N/LOBA_K");
   end

   loba_op_t op_a, op_b;
   loba_op_t a1, b1;

   logic             v1, v2, v3;
   logic             ld1, ld2, ld3;
   logic             mv1, mv2, mv3;
   logic [PRODW-1:0] prod2;
   logic [SHW:0]     sh2;
   logic             sign2;
   logic [2*N-1:0]   mag3;
   logic [2*N-1:0]   p_next;

   loba_seg #(.N(N), .K(K), .SIGNED(SIGNED)) u_seg_a (.x(in_a), .op(op_a));
   loba_seg #(.N(N), .K(K), .SIGNED(SIGNED)) u_seg_b (.x(in_b), .op(op_b));

   // Ready ripples back from out_ready so a full pipe still accepts while draining.
   always_comb begin
      mv3      = v3 & out_ready;
      ld3      = !v3 | mv3;
      mv2      = v2 & ld3;
      ld2      = !v2 | mv2;
      mv1      = v1 & ld2;
      ld1      = !v1 | mv1;
      in_ready = ld1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (ld1) v1 <= in_valid;
         if (ld2) v2 <= v1;
         if (ld3) v3 <= v2;
      end
   end

   always_ff @(posedge clk) begin
      if (ld1 && in_valid) begin
         a1 <= op_a;
         b1 <= op_b;
      end
      if (ld2 && v1) begin
         prod2 <= PRODW'(a1.seg) * PRODW'(b1.seg);
         sh2   <= {1'b0, a1.sh} + {1'b0, b1.sh};
         sign2 <= a1.sign ^ b1.sign;
      end
   end

   // A zero magnitude is never negated, so the product is always +0.
   always_comb begin
      mag3   = (2*N)'(prod2) << sh2;
      p_next = (SIGNED && sign2 && (mag3 != '0)) ? (~mag3 + 1'b1) : mag3;
   end

   always_ff @(posedge clk) begin
      if (rst)              out_p <= '0;
      else if (ld3 && v2)   out_p <= p_next;
   end

   assign out_valid = v3;

endmodule

// File: tb/tb_loba_mult_pipe.sv
// Scoreboard bench for loba_mult_pipe: an unsigned and a signed instance share one stimulus stream.
// Expected values follow LOBA_ROUND_EN when it is defined.
module tb_loba_mult_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] in_a, in_b;
   logic        in_ready_u, in_ready_s;
   logic        out_valid_u, out_valid_s;
   logic [31:0] out_p_u, out_p_s;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] q_u[$];
   logic [31:0] q_s[$];
   bit          rand_bp = 1'b0;

`ifdef LOBA_ROUND_EN
   localparam logic [31:0] E_B7   = 32'd920;
   localparam logic [31:0] E_FF   = 32'hF040_0000;
   localparam logic [31:0] E_8000 = 32'hFFFF_7800;
`else
   localparam logic [31:0] E_B7   = 32'd880;
   localparam logic [31:0] E_FF   = 32'hE100_0000;
   localparam logic [31:0] E_8000 = 32'hFFFF_8000;
`endif

   always #5 clk = ~clk;

   loba_mult_pipe #(.N(16), .K(4), .SIGNED(1'b0)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid_u), .out_ready(out_ready),
      .out_p(out_p_u));

   loba_mult_pipe #(.N(16), .K(4), .SIGNED(1'b1)) u_sdut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid_s), .out_ready(out_ready),
      .out_p(out_p_s));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic void seg_of(input logic [15:0] m, output longint seg, output int sh);
      int p;
      sh  = 0;
      seg = longint'(m);
      if (m >= 16'd16) begin
         p = 15;
         while (!m[p]) p--;
         sh  = p - 3;
         seg = longint'(m >> sh);
      end
`ifdef LOBA_ROUND_EN
      if (sh > 0) begin
         seg = seg * 2 + 1;
         sh  = sh - 1;
      end
`endif
   endfunction

   function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input bit sgn);
      logic [15:0] ma, mb;
      longint      sa, sb, prod;
      int          ha, hb;
      logic [31:0] r;
      ma = (sgn && a[15]) ? (16'd0 - a) : a;
      mb = (sgn && b[15]) ? (16'd0 - b) : b;
      seg_of(ma, sa, ha);
      seg_of(mb, sb, hb);
      prod = (sa * sb) << (ha + hb);
      r    = prod[31:0];
      if (sgn && (a[15] ^ b[15]) && r != 32'd0) r = 32'd0 - r;
      return r;
   endfunction

   // Output side of the scoreboard: pop on every completed output transfer.
   always @(negedge clk) begin
      if (!rst && out_valid_u && out_ready) begin
         n_tests++;
         assert (q_u.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_out_u observed=0x%08h expected=no_output", out_p_u);
         end
         if (q_u.size() != 0) check("out_p_u", out_p_u, q_u.pop_front());
      end
      if (!rst && out_valid_s && out_ready) begin
         n_tests++;
         assert (q_s.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_out_s observed=0x%08h expected=no_output", out_p_s);
         end
         if (q_s.size() != 0) check("out_p_s", out_p_s, q_s.pop_front());
      end
   end

   always @(posedge clk) begin
      if (rand_bp) begin
         #1;
         out_ready = ($urandom_range(0, 2) != 0);
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] eu, input logic [31:0] es, output int waited);
      bit accepted;
      accepted = 1'b0;
      waited   = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      while (!accepted && waited <= 50) begin
         @(negedge clk);
         if (in_ready_u) begin
            q_u.push_back(eu);
            q_s.push_back(es);
            accepted = 1'b1;
         end else begin
            waited++;
         end
         @(posedge clk);
         #1;
      end
      n_tests++;
      assert (accepted) else begin
         n_fail++;
         $error("FAIL send_timeout observed=not_accepted expected=accepted a=0x%04h", a);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int          w;
      int          hits;
      logic [31:0] hold;
      logic [15:0] ra, rb;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      @(negedge clk);
      check("rst_out_valid_u", 32'(out_valid_u), 32'd0);
      check("rst_out_p_u",     out_p_u,          32'd0);
      check("rst_in_ready_u",  32'(in_ready_u),  32'd1);
      check("rst_in_ready_s",  32'(in_ready_s),  32'd1);
      @(posedge clk);
      #1;

      // Latency: output appears at the third sample after the accept edge.
      send(16'h00B7, 16'h0005, E_B7, E_B7, w);
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_stage1", 32'(out_valid_u), 32'd0);
      @(negedge clk);
      check("lat_stage2", 32'(out_valid_u), 32'd0);
      @(negedge clk);
      check("lat_stage3", 32'(out_valid_u), 32'd1);
      @(posedge clk);
      #1;
      idle(3);

      // Directed vectors, back to back at full rate.
      send(16'h0009, 16'h0007, 32'd63, 32'd63, w);
      check("tput_wait0", 32'(w), 32'd0);
      send(16'h0000, 16'hFFFF, 32'd0, 32'd0, w);
      check("tput_wait1", 32'(w), 32'd0);
      send(16'hFFFF, 16'hFFFF, E_FF, model(16'hFFFF, 16'hFFFF, 1'b1), w);
      check("tput_wait2", 32'(w), 32'd0);
      send(16'hFFFD, 16'h0005, model(16'hFFFD, 16'h0005, 1'b0), 32'hFFFF_FFF1, w);
      check("tput_wait3", 32'(w), 32'd0);
      send(16'h8000, 16'h0001, model(16'h8000, 16'h0001, 1'b0), E_8000, w);
      check("tput_wait4", 32'(w), 32'd0);
      idle(6);

      // Backpressure: three accepts fill the pipe, the fourth waits.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_a     = 16'h0100 + 16'(i * 37);
         in_b     = 16'h0033 + 16'(i);
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready_u), (i < 3) ? 32'd1 : 32'd0);
         if (in_ready_u) begin
            q_u.push_back(model(in_a, in_b, 1'b0));
            q_s.push_back(model(in_a, in_b, 1'b1));
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      hold = out_p_u;
      check("bp_out_valid", 32'(out_valid_u), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_p", out_p_u, hold);
      check("bp_still_blocked", 32'(in_ready_u), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", 32'(in_ready_u), 32'd1);
      check("bp_drain0", 32'(out_valid_u), 32'd1);
      if (in_ready_u) begin
         q_u.push_back(model(in_a, in_b, 1'b0));
         q_s.push_back(model(in_a, in_b, 1'b1));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         check("bp_drain_gapless", 32'(out_valid_u), 32'd1);
      end
      @(posedge clk);
      #1;
      idle(4);

      // Random operands at full rate.
      for (int i = 0; i < 16; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         send(ra, rb, model(ra, rb, 1'b0), model(ra, rb, 1'b1), w);
         check("rand_tput_wait", 32'(w), 32'd0);
      end
      idle(5);

      // Random operands with random consumer stalls.
      rand_bp = 1'b1;
      for (int i = 0; i < 30; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 5 == 0) begin
            ra = 16'($urandom_range(0, 20));
         end
         send(ra, rb, model(ra, rb, 1'b0), model(ra, rb, 1'b1), w);
         if (i % 7 == 3) idle(1);
      end
      in_valid = 1'b0;
      rand_bp  = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      idle(8);

      // Reset with two pairs in flight: both must vanish.
      send(16'h1234, 16'h0F0F, 32'd0, 32'd0, w);
      send(16'h7777, 16'h0003, 32'd0, 32'd0, w);
      in_valid = 1'b0;
      rst      = 1'b1;
      q_u.delete();
      q_s.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid_u", 32'(out_valid_u), 32'd0);
      check("midrst_out_valid_s", 32'(out_valid_s), 32'd0);
      check("midrst_out_p_u",     out_p_u,          32'd0);
      check("midrst_in_ready_u",  32'(in_ready_u),  32'd1);
      hits = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid_u || out_valid_s) hits++;
      end
      check("midrst_no_output", 32'(hits), 32'd0);
      @(posedge clk);
      #1;

      send(16'h00B7, 16'h0005, E_B7, E_B7, w);
      idle(1);

      hits = 0;
      while ((q_u.size() != 0 || q_s.size() != 0) && hits < 30) begin
         @(posedge clk);
         #1;
         hits++;
      end
      check("drain_q_u", 32'(q_u.size()), 32'd0);
      check("drain_q_s", 32'(q_s.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/loba_mult_pipe.md
# loba_mult_pipe

Pipelined, parametrised leading-one-bit-approximation (LOBA) multiplier with valid/ready streaming handshake on input and output. It is the next generation of the team's combinational LOBA multiplier. It adds a registered 3-stage datapath, backpressure, a signed-operand mode and compile-time midpoint compensation. It sits between operand producers and accumulation/consumer logic in the approximate-arithmetic datapath, sustaining one product per cycle.

## Interface
- N, 16, operand width in bits (≥ K+1)
- K, 4, retained segment width below and including the leading one (2 ≤ K ≤ N-1)
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and product
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operand pair this cycle
- in_a  in  N  operand A
- in_b  in  N  operand B
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product this cycle
- out_p  out  2N  approximate product

## Operation
- Magnitude: if SIGNED=1, each operand becomes |x| (N-bit unsigned; -2^(N-1) → 2^(N-1)), sign_p = sign_a ^ sign_b; SIGNED=0 uses operands directly with sign_p = 0.
- Segment extraction per magnitude m: p = leading-one index.
  - m < 2^K: seg = m[K-1:0], sh = 0 (exact).
  - Otherwise: seg = m[p:p-K+1], sh = p-K+1.
  - m = 0: seg = 0, sh = 0.
- Product magnitude = (seg_a × seg_b) << (sh_a + sh_b), truncated to 2N bits (never overflows: ≤ 2^(2N) - 1).
- SIGNED=1: out_p = -magnitude if sign_p and magnitude ≠ 0, else magnitude; zero product is always +0.
- Stage S1 registers seg/sh/sign for both operands. S2 registers the 2K-bit (or 2K+2, see Configuration) product and the summed shift. S3 registers the shifted, signed out_p.
- Each stage holds a valid bit. A stage loads when it is empty or its contents move forward this cycle. Stage k's contents move forward when stage k+1 loads; S3's move when out_valid & out_ready.
- in_ready = !S1.valid | S1 moves forward, a combinational chain from out_ready. Transfer occurs on in_valid & in_ready.
- out_valid = S3.valid. out_p holds stable while out_valid & !out_ready.

## Timing
- Latency 3 cycles: pair accepted at edge t, out_valid at edge t+3 when no stall.
- Throughput 1 product/cycle with out_ready held high; in_ready stays high.
- Capacity 3 in-flight pairs. With out_ready=0, in_ready drops after the 3rd accept.
- Reset: all stage valid bits = 0, out_valid = 0, out_p = 0, in_ready = 1 in the cycle after rst. Asserting rst mid-operation discards in-flight pairs; no output is produced for them.
- Simultaneous accept at input and drain at output in the same cycle is legal and loses nothing.
- Data registers are not reset, except out_p.

## Configuration
- LOBA_ROUND_EN defined: midpoint compensation. When sh > 0, the segment becomes the (K+1)-bit value {seg, 1'b1} and sh becomes sh-1. Operands with sh = 0 are unchanged and exact. The S2 multiplier widens to (K+1)×(K+1).
- Undefined: pure truncation as in Operation; K×K multiplier.

## Structure
- Package loba_pkg: segment-width and shift-width localparams (SHW = $clog2(N)+1), and a function for the leading-one index. It also holds a packed struct for the S1 operand record (seg, sh, sign).
- Sub-module loba_seg: combinational magnitude + leading-one + segment extraction, parameterised N, K, SIGNED. It is instantiated twice (A, B) ahead of the S1 register.
- Top loba_mult_pipe: handshake/valid chain, S2 multiply, S3 shift and sign.

## Test plan
- N=16, K=4, unsigned, truncation: A=0x00B7, B=0x0005 → out_p=880 (0x370), 3 cycles after accept. With LOBA_ROUND_EN → 920 (0x398).
- Exact and zero: A=9, B=7 → 63. A=0, B=0xFFFF → 0.
- Extremes: A=B=0xFFFF → 0xE1000000. With LOBA_ROUND_EN → 0xF0400000.
- SIGNED=1: A=0xFFFD (-3), B=5 → 0xFFFFFFF1 (-15). A=0x8000, B=1 → 0xFFFF8000.
- Backpressure: out_ready=0 and 4 consecutive in_valid → 3 accepts, in_ready=0 on the 4th. out_p holds stable. Raising out_ready drains all 4 in order, 1 per cycle.
- Reset mid-flight: rst for one cycle with 2 pairs in flight → out_valid=0, out_p=0, in_ready=1 next cycle. The discarded pairs never appear at the output.
